// File: rtl/dsp_pkg.sv
// Shared types and saturating-arithmetic helpers for the DSP product/MAC pipeline.
// Helpers work on a 64-bit signed carrier, so every accumulator width used with them must stay below 64.
package dsp_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_res_t;

    function automatic logic signed [SAT_W-1:0] acc_max(input int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] acc_min(input int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

    // Both operands arrive already sign-extended, and each fits in aw bits (aw < 64).
    // The 64-bit add therefore cannot wrap, and clamping is a plain range compare.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int                      aw);
        sat_res_t                res;
        logic signed [SAT_W-1:0] s;
        s       = a + b;
        res.sum = s;
        res.ovf = 1'b0;
        if (s > acc_max(aw)) begin
            res.sum = acc_max(aw);
            res.ovf = 1'b1;
        end else if (s < acc_min(aw)) begin
            res.sum = acc_min(aw);
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsp_sat_adder.sv
// Combinational saturating adder: accumulator (AW bits) plus sign-extended operand (PW bits).
// Result clamps to the AW-bit signed range, and ovf flags when clamping happened.
module dsp_sat_adder
    import dsp_pkg::*;
#(
    parameter int AW = 40,
    parameter int PW = 32
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [PW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);

    logic signed [SAT_W-1:0] a_ext;
    logic signed [SAT_W-1:0] b_ext;
    sat_res_t                res;

    always_comb begin
        a_ext = {{(SAT_W-AW){a[AW-1]}}, a};
        b_ext = {{(SAT_W-PW){b[PW-1]}}, b};
        res   = sat_add(a_ext, b_ext, AW);
        sum   = res.sum[AW-1:0];
        ovf   = res.ovf;
    end

endmodule

// File: rtl/dsp_prod_accum.sv
// Frame accumulator behind the 16x16 multiplier: sums products over in_last-delimited frames
// with saturation, then holds the result on a valid/ready port until the sink takes it.
module dsp_prod_accum
    import dsp_pkg::*;
#(
    parameter int PW = 32,
    parameter int AW = 40,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf,
    output logic [CW-1:0] out_count
);

    state_t               state_reg, state_next;
    logic signed [AW-1:0] acc_reg, acc_next;
    logic [CW-1:0]        count_reg, count_next;
    logic                 ovf_reg, ovf_next;
    logic [AW-1:0]        out_sum_reg, out_sum_next;
    logic                 out_ovf_reg, out_ovf_next;
    logic [CW-1:0]        out_count_reg, out_count_next;

    logic signed [AW-1:0] add_sum;
    logic                 add_ovf;
    logic [CW-1:0]        count_inc;
    logic                 beat;

    dsp_sat_adder #(
        .AW(AW),
        .PW(PW)
    ) u_sat_adder (
        .a  (acc_reg),
        .b  (in_data),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);
    assign out_sum   = out_sum_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_count = out_count_reg;

    assign beat      = in_valid && in_ready;
    assign count_inc = (count_reg == {CW{1'b1}}) ? count_reg : count_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        count_next     = count_reg;
        ovf_next       = ovf_reg;
        out_sum_next   = out_sum_reg;
        out_ovf_next   = out_ovf_reg;
        out_count_next = out_count_reg;

        case (state_reg)
            ACC: begin
                // clr takes priority, so a beat arriving alongside it is swallowed, last or not.
                if (clr) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end else if (beat) begin
                    acc_next   = add_sum;
                    count_next = count_inc;
                    ovf_next   = ovf_reg | add_ovf;
                    if (in_last) begin
                        state_next     = HOLD;
                        out_sum_next   = add_sum;
                        out_ovf_next   = ovf_reg | add_ovf;
                        out_count_next = count_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next     = ACC;
                    acc_next       = '0;
                    count_next     = '0;
                    ovf_next       = 1'b0;
                    out_sum_next   = '0;
                    out_ovf_next   = 1'b0;
                    out_count_next = '0;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            out_sum_reg   <= '0;
            out_ovf_reg   <= 1'b0;
            out_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            count_reg     <= count_next;
            ovf_reg       <= ovf_next;
            out_sum_reg   <= out_sum_next;
            out_ovf_reg   <= out_ovf_next;
            out_count_reg <= out_count_next;
        end
    end

endmodule

// File: tb/tb_dsp_prod_accum.sv
// Randomized and directed bench for dsp_prod_accum, with two instances run in lockstep:
// a 40-bit accumulator with a 16-bit count, and a 34-bit accumulator with a 3-bit count so saturation is reachable.
module tb_dsp_prod_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [39:0] out_sum_a;
    logic [15:0] out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [33:0] out_sum_b;
    logic [2:0]  out_count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_frame = 0;

    // Reference model: one entry per instance (0 = AW40/CW16, 1 = AW34/CW3).
    longint m_acc[2];
    bit     m_ovf[2];
    longint m_cnt[2];
    int     aw_of[2];
    int     cw_of[2];

    always #5 clk = ~clk;

    dsp_prod_accum #(.PW(32), .AW(40), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_ovf(out_ovf_a), .out_count(out_count_a)
    );

    dsp_prod_accum #(.PW(32), .AW(34), .CW(3)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b), .out_count(out_count_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sum_a_val();
        return longint'(signed'(out_sum_a));
    endfunction

    function automatic longint sum_b_val();
        return longint'(signed'(out_sum_b));
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_beat(input logic [31:0] d);
        longint lo, hi, s;
        for (int k = 0; k < 2; k++) begin
            hi = (longint'(1) << (aw_of[k] - 1)) - 1;
            lo = -(longint'(1) << (aw_of[k] - 1));
            s  = m_acc[k] + longint'(signed'(d));
            if (s > hi) begin
                s = hi;
                m_ovf[k] = 1'b1;
            end else if (s < lo) begin
                s = lo;
                m_ovf[k] = 1'b1;
            end
            m_acc[k] = s;
            if (m_cnt[k] < (longint'(1) << cw_of[k]) - 1)
                m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    // Present one beat once the stage is ready; returns just after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input bit last, input bit c, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        while (!in_ready_a && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready_a) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        clr      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
        if (c) model_clear();
        else   model_beat(d);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_valid_a"}, out_valid_a, 1);
        chk({tag, "_ready_a"}, in_ready_a, 0);
        chk({tag, "_sum_a"},   sum_a_val(), m_acc[0]);
        chk({tag, "_ovf_a"},   out_ovf_a, m_ovf[0]);
        chk({tag, "_cnt_a"},   out_count_a, m_cnt[0]);
        chk({tag, "_valid_b"}, out_valid_b, 1);
        chk({tag, "_ready_b"}, in_ready_b, 0);
        chk({tag, "_sum_b"},   sum_b_val(), m_acc[1]);
        chk({tag, "_ovf_b"},   out_ovf_b, m_ovf[1]);
        chk({tag, "_cnt_b"},   out_count_b, m_cnt[1]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid_a"}, out_valid_a, 0);
        chk({tag, "_ready_a"}, in_ready_a, 1);
        chk({tag, "_sum_a"},   sum_a_val(), 0);
        chk({tag, "_ovf_a"},   out_ovf_a, 0);
        chk({tag, "_cnt_a"},   out_count_a, 0);
        chk({tag, "_valid_b"}, out_valid_b, 0);
        chk({tag, "_sum_b"},   sum_b_val(), 0);
        chk({tag, "_cnt_b"},   out_count_b, 0);
    endtask

    // Check the result one cycle after the last beat, stall `hold` cycles, then hand it off.
    task automatic finish_frame(input int hold);
        @(negedge clk);
        chk_result("res");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk_result("hold");
        end
        clr       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        $display("[TB] frame %0d: sum40=%0d ovf40=%0b cnt16=%0d sum34=%0d ovf34=%0b cnt3=%0d hold=%0d",
                 n_frame, m_acc[0], m_ovf[0], m_cnt[0], m_acc[1], m_ovf[1], m_cnt[1], hold);
        n_frame++;
        model_clear();
        @(negedge clk);
        chk_idle("after_hs");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aw_of[0] = 40; cw_of[0] = 16;
        aw_of[1] = 34; cw_of[1] = 3;
        model_clear();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("reset");

        // Ten beats of 837.
        for (int i = 0; i < 10; i++) send_beat(32'd837, i == 9, 1'b0, 0);
        finish_frame(0);

        // Three beats of -837.
        for (int i = 0; i < 3; i++) send_beat(32'hFFFF_FCBB, i == 2, 1'b0, 0);
        finish_frame(0);

        // Five beats of max positive product saturates the 34-bit instance only.
        for (int i = 0; i < 5; i++) send_beat(32'h7FFF_FFFF, i == 4, 1'b0, 0);
        finish_frame(0);
        send_beat(32'd396, 1'b1, 1'b0, 0);
        finish_frame(0);

        // Large negative products drive the 34-bit instance to its negative clamp.
        for (int i = 0; i < 6; i++) send_beat(32'h8000_0000, i == 5, 1'b0, 0);
        finish_frame(1);

        // Backpressure: a stalled beat is presented throughout HOLD and is taken only after the handshake.
        send_beat(32'd396, 1'b0, 1'b0, 0);
        send_beat(32'd396, 1'b1, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd55;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_result("bp");
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        chk("bp_ready_after_hs", in_ready_a, 1);
        chk("bp_valid_after_hs", out_valid_a, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_beat(32'd55);
        finish_frame(0);

        // clr together with the last beat discards the frame.
        for (int i = 0; i < 4; i++) send_beat(32'd100, 1'b0, 1'b0, 0);
        send_beat(32'd100, 1'b1, 1'b1, 0);
        repeat (2) begin
            @(negedge clk);
            chk("clr_no_valid", out_valid_a, 0);
        end
        send_beat(32'd7, 1'b1, 1'b0, 0);
        finish_frame(0);

        // clr during HOLD must not disturb the pending result.
        send_beat(32'd5, 1'b0, 1'b0, 0);
        send_beat(32'd6, 1'b1, 1'b0, 0);
        clr = 1'b1;
        finish_frame(3);

        // Asynchronous reset in HOLD drops the pending result at once.
        for (int i = 0; i < 10; i++) send_beat(32'd837, i == 9, 1'b0, 0);
        @(negedge clk);
        chk("pre_rst_sum", sum_a_val(), 8370);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid_a, 0);
        chk("rst_sum", sum_a_val(), 0);
        chk("rst_cnt", out_count_a, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        send_beat(32'd22, 1'b1, 1'b0, 0);
        finish_frame(0);

        // Randomized frames with idle gaps and random sink stalls.
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++)
                send_beat($urandom, i == n - 1, 1'b0, $urandom_range(0, 2));
            finish_frame($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_prod_accum.md
Name: dsp_prod_accum

Overview:
- Downstream stage of the 16x16 signed DSP multiplier. Consumes its 32-bit product stream and accumulates products over variable-length frames into a wide signed accumulator with saturation.
- Presents each completed frame sum on a valid/ready output port.
- Sits between the multiplier output and the result sink (FIFO or register bank), turning a per-cycle product into a MAC result.

Parameters:
- PW, 32, product width (signed, two's complement)
- AW, 40, accumulator/output width; must satisfy AW > PW
- CW, 16, beat-counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort of the partial frame
- in_valid  in  1  product beat present
- in_ready  out  1  stage accepts a beat
- in_data  in  PW  signed product (multiplier p output)
- in_last  in  1  beat is the final beat of its frame
- out_valid  out  1  frame result present
- out_ready  in  1  sink accepts the result
- out_sum  out  AW  signed saturated frame sum
- out_ovf  out  1  saturation occurred at least once in the frame
- out_count  out  CW  beats in the frame, saturating at 2^CW-1

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=ACC, acc=0, count=0, ovf=0.
  - out_valid=0, out_sum=0, out_ovf=0, out_count=0, in_ready=1 after reset release.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1; out_sum, out_ovf and out_count are held stable.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Accumulation on an accepted beat:
  - acc_next = sat_AW(acc + sext(in_data)).
  - Signed overflow clamps to +2^(AW-1)-1 or -2^(AW-1) and sets ovf (sticky until the frame completes).
  - Once saturated, later beats keep accumulating from the clamped value; there is no wrap-around.
- Counting: count increments per accepted beat and holds at 2^CW-1.
- Frame end: an accepted beat with in_last=1 moves ACC->HOLD.
  - The output registers load the sum, ovf and count including that beat.
  - out_valid rises on the following clock edge, giving 1-cycle latency from the last beat to the result.
- Output handshake: in HOLD, out_valid && out_ready -> ACC on the next edge.
  - acc, count and ovf clear to 0; out_sum, out_ovf and out_count are also cleared to 0.
  - The next frame's first beat is accepted no earlier than the cycle after the handshake; there is no bubble-free pass-through.
- Flow control while HOLD is asserted:
  - out_valid stays high and all out_* values stay unchanged until out_ready is seen.
  - Upstream is stalled via in_ready=0.
- clr in ACC: acc, count and ovf clear to 0. A beat accepted in the same cycle is consumed and discarded, even if in_last=1; clr wins and there is no HOLD entry.
- clr in HOLD: ignored; the pending result is never dropped.
- Single-beat frame: in_last on the first beat gives out_sum = sext(in_data), out_count=1.
- Reset asserted mid-frame or in HOLD: all state and outputs are lost immediately; the partial or pending result is discarded.

Decomposition:
- Shared package dsp_pkg:
  - state enum {ACC, HOLD}
  - localparam functions for AW max/min constants
  - sat_add helper function (sign-extend, add, clamp, report overflow)
- One natural sub-module: dsp_sat_adder, combinational; inputs a[AW], b[PW]; outputs sum[AW] and ovf. It is reused by later MAC stages.
- The FSM, counter and output registers stay in dsp_prod_accum.

Test Plan:
1. Ten beats of in_data=837 (38*22+1), last on beat 10, out_ready=1 -> one cycle later out_valid=1, out_sum=8370, out_count=10, out_ovf=0; ACC on the next edge.
2. Three beats of in_data=-837 (0xFFFFFCBB) -> out_sum=-2511 sign-extended to 40 bits, out_count=3.
3. Saturation, with AW=34:
   - Five beats of 0x7FFFFFFF -> out_sum=8589934591, out_ovf=1, out_count=5.
   - Next frame with one beat of 396 (33*12) -> out_sum=396, out_ovf=0.
4. Backpressure:
   - Frame of two beats of 396, out_ready=0 for 5 cycles -> out_valid and out_sum=792 held stable, in_ready=0 throughout, and in_valid beats presented are not consumed.
   - out_ready=1 -> handshake, then the stalled beat is accepted.
5. clr behaviour:
   - Mid-frame: after 4 beats of 100, clr together with in_last beat 100 -> no out_valid; next frame of one beat of 7 gives out_sum=7, out_count=1.
   - In HOLD: clr has no effect on the pending result.
6. Reset mid-operation:
   - rst=0 asserted asynchronously between edges while in HOLD (out_sum=8370) -> out_valid=0 and out_sum=0 immediately.
   - After release, a one-beat frame of 22 gives out_sum=22.
